// File: rtl/fifo_write_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_write_arb_pkg
// Shared types and constants for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE = no owner, GRANT = owner holds port)
//   BEAT_CNT_W  : width of the per-grant accepted-beat counter
// -----------------------------------------------------------------------------
package fifo_write_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 8;

endpackage : fifo_write_arb_pkg

// File: rtl/fifo_write_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select. Searches req upward from (base+1) with
// wrap-around; base itself is the lowest-priority candidate, so a lone
// request from base is still picked.
//   req    in  NUM_REQ   request vector
//   base   in  ID_WIDTH  index that was served last
//   valid  out 1         at least one request present
//   winner out ID_WIDTH  selected index (0 when no request)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] base,
    output logic                valid,
    output logic [ID_WIDTH-1:0] winner
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid  = |req;
        winner = '0;
        // Wrapped half (indices <= base): lowest index wins after the scan.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(base))) winner = ID_WIDTH'(i);
        end
        // Upper half (indices > base) outranks the wrapped half.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(base))) winner = ID_WIDTH'(i);
        end
    end

endmodule : rr_picker

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One owner is granted at a time; its data is forwarded and its full_n is the
// FIFO's full_n. A grant ends when the owner drops wr_en or when it completes
// its burst, and the next requester is granted on the same edge.
//
// Build option: FIFO_WRITE_ARB_BURST_EN
//   defined   : an owner may write up to MAX_BURST beats per grant
//   undefined : grant rotates after every accepted beat (MAX_BURST unused)
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   req_wr_en     per-producer write strobe
//   req_wr_data   producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_full_n    per-producer ready; only the owner's bit can be 1
//   fifo_wr_en    FIFO WR_EN
//   fifo_wr_data  FIFO WR_DATA (0 when no owner)
//   fifo_full_n   FIFO FULL_N
//   grant_valid   an owner is granted (registered)
//   grant_id      current owner, 0 when no grant (registered)
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_write_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_wr_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]            req_full_n,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full_n,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    arb_state_t          state;
    logic [ID_WIDTH-1:0] owner;
    logic [ID_WIDTH-1:0] last_owner;

    logic                owner_req;
    logic                beat;
    logic                burst_last;
    logic                grant_end;
    logic                pick_valid;
    logic [ID_WIDTH-1:0] pick_base;
    logic [ID_WIDTH-1:0] pick_winner;

    assign owner_req = req_wr_en[owner];

    // Port steering is combinational from the registered owner so the first
    // beat can happen in the cycle right after the grant edge.
    always_comb begin
        req_full_n   = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state == GRANT) begin
            // Gate with reset so no handshake completes in a reset cycle.
            req_full_n[owner] = fifo_full_n & ~reset;
            fifo_wr_en        = owner_req & fifo_full_n & ~reset;
            fifo_wr_data      = req_wr_data[owner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign beat = fifo_wr_en;

`ifdef FIFO_WRITE_ARB_BURST_EN
    logic [BEAT_CNT_W-1:0] beat_cnt;

    assign burst_last = (beat_cnt == BEAT_CNT_W'(MAX_BURST - 1));

    // Counts accepted beats of the current grant; stalls do not advance it.
    always_ff @(posedge clk) begin
        if (reset || (state != GRANT) || grant_end) beat_cnt <= '0;
        else if (beat)                              beat_cnt <= beat_cnt + 1'b1;
    end
`else
    assign burst_last = 1'b1;
`endif

    // Release (no beat) or final beat of the burst ends the grant.
    assign grant_end = ~owner_req | (beat & burst_last);

    // In GRANT the search starts after the current owner, which excludes it
    // unless it is the only requester (then the search wraps back to it).
    assign pick_base = (state == GRANT) ? owner : last_owner;

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_picker (
        .req    (req_wr_en),
        .base   (pick_base),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= ID_WIDTH'(NUM_REQ - 1);
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state       <= GRANT;
                        owner       <= pick_winner;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_winner;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        last_owner <= owner;
                        if (pick_valid) begin
                            owner    <= pick_winner;
                            grant_id <= pick_winner;
                        end else begin
                            state       <= IDLE;
                            owner       <= '0;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : fifo_write_arbiter

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed scenarios followed by randomized traffic. Producers are modelled as
// beat budgets that hold wr_en/data until their ready is seen. A reference
// model tracks the grant at transaction level (owner index or none, beats
// taken, round-robin search by modular distance) and predicts every output.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IDW = 2;
    localparam int MB  = 4;
`ifdef FIFO_WRITE_ARB_BURST_EN
    localparam int EFF_BURST = MB;
`else
    localparam int EFF_BURST = 1;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_wr_en = '0;
    logic [N*DW-1:0] req_wr_data = '0;
    logic [N-1:0]    req_full_n;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            fifo_full_n = 1'b1;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IDW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_wr_en    (req_wr_en),
        .req_wr_data  (req_wr_data),
        .req_full_n   (req_full_n),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full_n  (fifo_full_n),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner < 0 means no grant.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_taken = 0;

    // Producers: remaining beats to send and the word currently offered.
    int            rem[N];
    logic [DW-1:0] pdata[N];
    int            beats_seen[N];

    // First requester found walking upward from start+1 with wrap; -1 if none.
    function automatic int rr_next(input logic [N-1:0] req, input int start);
        for (int d = 1; d <= N; d++) begin
            if (req[(start + d) % N]) return (start + d) % N;
        end
        return -1;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict and compare, clock, advance model and
    // producers. reload_pct = chance an idle producer starts a new batch.
    task automatic step(input int reload_pct);
        logic [N-1:0]  req_snap;
        logic [N-1:0]  hs;
        logic          exp_en;
        logic [N-1:0]  exp_fn;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < N; i++) begin
            req_wr_en[i]             = (rem[i] > 0);
            req_wr_data[i*DW +: DW]  = pdata[i];
        end
        #3;
        req_snap = req_wr_en;
        exp_en = 1'b0;
        exp_fn = '0;
        exp_d  = '0;
        if (m_owner >= 0) begin
            exp_d = pdata[m_owner];
            if (!reset) begin
                exp_fn[m_owner] = fifo_full_n;
                exp_en          = req_snap[m_owner] & fifo_full_n;
            end
        end
        chk_bit("fifo_wr_en", fifo_wr_en, exp_en);
        chk_vec("fifo_wr_data", fifo_wr_data, exp_d);
        chk_vec("req_full_n", DW'(req_full_n), DW'(exp_fn));
        chk_bit("grant_valid", grant_valid, m_owner >= 0);
        chk_vec("grant_id", DW'(grant_id), (m_owner >= 0) ? DW'(m_owner) : '0);
        if (fifo_wr_en) beats_seen[grant_id]++;
        hs = req_wr_en & req_full_n;

        @(posedge clk);

        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_taken = 0;
        end else if (m_owner < 0) begin
            m_owner = rr_next(req_snap, m_last);
            m_taken = 0;
        end else begin
            bit ended;
            ended = 1'b0;
            if (!req_snap[m_owner]) ended = 1'b1;
            else if (exp_en) begin
                m_taken++;
                if (m_taken == EFF_BURST) ended = 1'b1;
            end
            if (ended) begin
                m_last  = m_owner;
                m_owner = rr_next(req_snap, m_owner);
                m_taken = 0;
            end
        end

        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                rem[i]--;
                pdata[i] = $urandom;
            end
            if (rem[i] == 0 && $urandom_range(99) < reload_pct) begin
                rem[i]   = $urandom_range(1, 9);
                pdata[i] = $urandom;
            end
        end
        #1;
    endtask

    task automatic run(input int cycles, input int reload_pct);
        for (int c = 0; c < cycles; c++) step(reload_pct);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) beats_seen[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i]        = 0;
            pdata[i]      = $urandom;
            beats_seen[i] = 0;
        end

        // Reset state.
        reset = 1'b1;
        run(2, 0);
        reset = 1'b0;
        run(2, 0);

        // Single requester 2: three beats, release, back to idle.
        clear_counts();
        rem[2] = 3;
        run(6, 0);
        n_cmp++;
        assert (beats_seen[2] === 3) else begin
            n_fail++;
            $error("FAIL single_req_beats observed=%0d expected=3", beats_seen[2]);
        end

        // All four continuously requesting, 8 beats each.
        clear_counts();
        for (int i = 0; i < N; i++) rem[i] = 8;
        run(40, 0);
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            assert (beats_seen[i] === 8) else begin
                n_fail++;
                $error("FAIL all_req_beats[%0d] observed=%0d expected=8", i, beats_seen[i]);
            end
        end

        // Backpressure mid-burst on owner 1.
        clear_counts();
        rem[1] = 10;
        run(3, 0);
        fifo_full_n = 1'b0;
        run(5, 0);
        fifo_full_n = 1'b1;
        run(12, 0);
        n_cmp++;
        assert (beats_seen[1] === 10) else begin
            n_fail++;
            $error("FAIL backpressure_beats observed=%0d expected=10", beats_seen[1]);
        end

        // Sole requester 3, six beats back to back.
        clear_counts();
        rem[3] = 6;
        run(10, 0);
        n_cmp++;
        assert (beats_seen[3] === 6) else begin
            n_fail++;
            $error("FAIL sole_req_beats observed=%0d expected=6", beats_seen[3]);
        end

        // Reset during owner 2's third beat; requester 0 then wins first.
        rem[2] = 8;
        run(3, 0);
        reset = 1'b1;
        run(1, 0);
        reset = 1'b0;
        rem[0] = 2;
        run(20, 0);

        // Randomized traffic with backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            fifo_full_n = ($urandom_range(99) < 75);
            reset       = ($urandom_range(499) == 0);
            step(30);
        end
        reset = 1'b0;
        fifo_full_n = 1'b1;
        run(10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fifo_write_arbiter
